// File: rtl/ball_motion.sv
// Ball producer for the brick game: serve, stepping, wall/paddle/brick bounces, misses, lives, win/over.
// Optional `SPEEDUP_EN: after 8 paddle bounces in one serve the ball steps on every move_tick.
module ball_motion #(
  parameter int PADDLE_ROW = 15,
  parameter int PADDLE_W   = 4,
  parameter int LIVES      = 3,
  parameter int MISS_TICKS = 4,
  parameter int BALL_DIV   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        move_tick,
  input  logic        launch,
  input  logic [3:0]  paddle_col,
  input  logic [55:0] Bricks,
  output logic [3:0]  Ball_rowIndex,
  output logic [3:0]  Ball_colIndex,
  output logic [1:0]  Ball_direction,
  output logic [1:0]  lives,
  output logic        game_over,
  output logic        game_win,
  output logic [2:0]  o_dbg_state
);
  typedef enum logic [2:0] {
    S_SERVE = 3'd0, S_MOVE = 3'd1, S_MISS = 3'd2, S_OVER = 3'd3, S_WIN = 3'd4
  } state_t;

  localparam logic [3:0]        REST_ROW   = 4'(PADDLE_ROW - 1);
  localparam logic signed [4:0] PAD_ROW    = 5'(PADDLE_ROW);
  localparam logic [4:0]        PAD_SPAN   = 5'(PADDLE_W - 1);
  localparam logic [1:0]        LIVES_INIT = 2'(LIVES);
  localparam logic [3:0]        MISS_LAST  = 4'(MISS_TICKS - 1);
  localparam logic [2:0]        DIV_N      = 3'(BALL_DIV);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_row, r_col, w_row_nxt, w_col_nxt;
  logic [1:0]  r_dir, w_dir_nxt, r_lives, w_lives_nxt;
  logic [2:0]  r_div, w_div_nxt;
  logic [3:0]  r_miss, w_miss_nxt;
  logic        r_over, r_win;

  logic signed [4:0] w_col_s, w_row_s, w_nc, w_nr;
  logic [1:0]  w_dir_b;
  logic        w_pad_zone, w_on_pad, w_brick_hit, w_step, w_fast;
  logic [4:0]  w_pad_hi;
  logic [5:0]  w_brick_idx;
  logic [2:0]  w_div_inc;
  logic [3:0]  w_serve_col;

  // Target cell after wall and ceiling reflections; a corner flips both bits.
  always_comb begin
    w_col_s = $signed({1'b0, r_col});
    w_row_s = $signed({1'b0, r_row});
    w_dir_b = r_dir;
    w_nc    = r_dir[0] ? w_col_s - 5'sd1 : w_col_s + 5'sd1;
    if (w_nc < 5'sd0 || w_nc > 5'sd15) begin
      w_dir_b[0] = ~r_dir[0];
      w_nc       = w_dir_b[0] ? w_col_s - 5'sd1 : w_col_s + 5'sd1;
    end
    if (!r_dir[1] && r_row == 4'd0) w_dir_b[1] = 1'b1;
    w_nr = w_dir_b[1] ? w_row_s + 5'sd1 : w_row_s - 5'sd1;
  end

  assign w_pad_zone  = w_dir_b[1] && (w_nr == PAD_ROW);
  assign w_pad_hi    = {1'b0, paddle_col} + PAD_SPAN;
  assign w_on_pad    = (w_nc[3:0] >= paddle_col) && ({1'b0, w_nc[3:0]} <= w_pad_hi);
  assign w_brick_idx = {w_nr[2:0] - 3'd1, w_nc[3:1]};
  assign w_brick_hit = (w_nr >= 5'sd1) && (w_nr <= 5'sd7) && Bricks[w_brick_idx];
  assign w_div_inc   = r_div + 3'd1;
  assign w_step      = move_tick && (w_fast || w_div_inc >= DIV_N);
  assign w_serve_col = (paddle_col == 4'd15) ? 4'd15 : paddle_col + 4'd1;

`ifdef SPEEDUP_EN
  logic [3:0] r_hits, w_hits_nxt;
  assign w_fast = (r_hits >= 4'd8);
`else
  assign w_fast = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_dir_nxt   = r_dir;
    w_lives_nxt = r_lives;
    w_div_nxt   = r_div;
    w_miss_nxt  = r_miss;
`ifdef SPEEDUP_EN
    w_hits_nxt  = r_hits;
`endif
    case (r_state)
      S_SERVE: begin
        w_row_nxt  = REST_ROW;
        w_col_nxt  = w_serve_col;
        w_dir_nxt  = 2'b00;
        w_miss_nxt = 4'd0;
`ifdef SPEEDUP_EN
        w_hits_nxt = 4'd0;
`endif
        if (launch) begin
          w_state_nxt = S_MOVE;
          w_div_nxt   = 3'd0;
        end
      end
      S_MOVE: begin
        if (Bricks == 56'd0) begin
          w_state_nxt = S_WIN;
        end else if (move_tick && !w_step) begin
          w_div_nxt = w_div_inc;
        end else if (w_step) begin
          w_div_nxt = 3'd0;
          w_col_nxt = w_nc[3:0];
          if (w_pad_zone && w_on_pad) begin
            w_dir_nxt = {1'b0, w_dir_b[0]};
`ifdef SPEEDUP_EN
            if (r_hits != 4'hF) w_hits_nxt = r_hits + 4'd1;
`endif
          end else if (w_pad_zone) begin
            w_row_nxt   = w_nr[3:0];
            w_dir_nxt   = w_dir_b;
            w_miss_nxt  = 4'd0;
            w_state_nxt = S_MISS;
          end else begin
            w_row_nxt = w_nr[3:0];
            w_dir_nxt = w_brick_hit ? {~w_dir_b[1], w_dir_b[0]} : w_dir_b;
          end
        end
      end
      S_MISS: begin
        if (move_tick) begin
          if (r_miss == MISS_LAST) begin
            w_miss_nxt  = 4'd0;
            w_lives_nxt = r_lives - 2'd1;
            w_state_nxt = (r_lives == 2'd1) ? S_OVER : S_SERVE;
          end else begin
            w_miss_nxt = r_miss + 4'd1;
          end
        end
      end
      default: begin
        if (launch) begin
          w_state_nxt = S_SERVE;
          w_lives_nxt = LIVES_INIT;
          w_div_nxt   = 3'd0;
          w_miss_nxt  = 4'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_SERVE;
      r_row   <= REST_ROW;
      r_col   <= 4'd7;
      r_dir   <= 2'b00;
      r_lives <= LIVES_INIT;
      r_div   <= 3'd0;
      r_miss  <= 4'd0;
      r_over  <= 1'b0;
      r_win   <= 1'b0;
`ifdef SPEEDUP_EN
      r_hits  <= 4'd0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_dir   <= w_dir_nxt;
      r_lives <= w_lives_nxt;
      r_div   <= w_div_nxt;
      r_miss  <= w_miss_nxt;
      r_over  <= (w_state_nxt == S_OVER);
      r_win   <= (w_state_nxt == S_WIN);
`ifdef SPEEDUP_EN
      r_hits  <= w_hits_nxt;
`endif
    end
  end

  assign Ball_rowIndex  = r_row;
  assign Ball_colIndex  = r_col;
  assign Ball_direction = r_dir;
  assign lives          = r_lives;
  assign game_over      = r_over;
  assign game_win       = r_win;
  assign o_dbg_state    = r_state;
endmodule
